// File: rtl/esc_pwm_multi.sv
// esc_pwm_multi: multi-channel ESC pulse generator on a shared frame timer.
// Ports: clk, rst (sync, active-high), en, sync_mode, wrt[NUM_CH],
//   speed[NUM_CH*SPEED_W] (packed per channel), pwm[NUM_CH],
//   frame_start, pend[NUM_CH] (captured speed awaiting next frame).
module esc_pwm_multi #(
  parameter int NUM_CH    = 4,
  parameter int SPEED_W   = 11,
  parameter int CNT_W     = 17,
  parameter int MIN_PULSE = 6250,
  parameter int GAIN      = 3,
  parameter int PERIOD    = 100000,
  parameter int SPEED_MAX = 2047
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      sync_mode,
  input  logic [NUM_CH-1:0]         wrt,
  input  logic [NUM_CH*SPEED_W-1:0] speed,
  output logic [NUM_CH-1:0]         pwm,
  output logic                      frame_start,
  output logic [NUM_CH-1:0]         pend
);

  // wide enough that MIN_PULSE + GAIN*speed never overflows
  localparam int WW = SPEED_W + 34;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(PERIOD - 1);
  localparam logic [WW-1:0] MIN_W  = WW'(MIN_PULSE);
  localparam logic [WW-1:0] GAIN_W = WW'(GAIN);
  localparam logic [WW-1:0] PER_W  = WW'(PERIOD);
  localparam logic [SPEED_W-1:0] SMAX =
    SPEED_W'(SPEED_MAX);

  // clip, scale, then saturate so the line drops
  // for at least one cycle before the next frame
  function automatic logic [CNT_W-1:0] pulse_w(
    input logic [SPEED_W-1:0] s
  );
    logic [SPEED_W-1:0] c;
    logic [WW-1:0]      w;
    c = (s > SMAX) ? SMAX : s;
    w = MIN_W + GAIN_W * WW'(c);
    if (w >= PER_W) w = PER_W - 1;
    return w[CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0] fcnt;
  logic             mode_q;
  logic             frm0;
  logic             mode_eff;

  assign frm0        = (fcnt == '0);
  assign frame_start = en & frm0 & ~rst;
  // a new mode is already in force on the boundary cycle itself
  assign mode_eff    = frm0 ? sync_mode : mode_q;

  always_ff @(posedge clk) begin
    if (rst)
      fcnt <= '0;
    else if (!en || fcnt == LAST)
      fcnt <= '0;
    else
      fcnt <= fcnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      mode_q <= 1'b0;
    else if (frm0)
      mode_q <= sync_mode;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SPEED_W-1:0] spd_in;
    logic [SPEED_W-1:0] shadow;
    logic [CNT_W-1:0]   hcnt;
    logic [CNT_W-1:0]   w_new;
    logic               start;
    logic               pwm_q;
    logic               pend_q;

    assign spd_in  = speed[i*SPEED_W +: SPEED_W];
    assign pwm[i]  = pwm_q;
    assign pend[i] = pend_q;

    // sync mode fires from the shadow only; immediate
    // mode fires from the live slice on the write
    always_comb begin
      start = 1'b0;
      w_new = pulse_w(shadow);
      if (mode_eff) begin
        start = frame_start;
      end else begin
        start = wrt[i];
        w_new = pulse_w(spd_in);
      end
    end

    always_ff @(posedge clk) begin
      if (rst)
        shadow <= '0;
      else if (wrt[i])
        shadow <= spd_in;
    end

    // a write on the frame_start cycle keeps pend set
    always_ff @(posedge clk) begin
      if (rst)
        pend_q <= 1'b0;
      else if (!mode_eff)
        pend_q <= 1'b0;
      else if (wrt[i])
        pend_q <= 1'b1;
      else if (frame_start)
        pend_q <= 1'b0;
    end

    always_ff @(posedge clk) begin
      if (rst || !en) begin
        pwm_q <= 1'b0;
        hcnt  <= '0;
      end else if (start) begin
        pwm_q <= 1'b1;
        hcnt  <= w_new - 1'b1;
      end else if (pwm_q) begin
        if (hcnt == '0)
          pwm_q <= 1'b0;
        else
          hcnt <= hcnt - 1'b1;
      end
    end
  end

endmodule
